cmac_tx_arbiter: RTL
====================

Name: cmac_tx_arbiter

Overview:
- Shares the single 512-bit CMAC TX user AXI-Stream port between two upstream packet sources.
- Arbitrates per packet (never interleaves beats of different packets), round-robin or fixed priority.
- Registered 2-entry skid output stage for timing closure at gt_clk; per-source frame counters for software monitoring.
- Sits directly in front of the CMAC TX user interface, in parallel with the TX speed monitor tap.

Parameters:
- DATA_W, 512, AXIS data width.
- KEEP_W, 64, AXIS keep width (DATA_W/8).
- CNT_W, 32, frame counter width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (source 0 always wins).

Ports:
- gt_clk  in  1  CMAC user clock; all logic synchronous to it.
- sys_reset_n  in  1  asynchronous active-low reset.
- arb_enable  in  1  1 = new grants allowed; 0 = finish current packet, then stop.
- cnt_clear  in  1  single-cycle pulse, clears both frame counters.
- s0_axis_tvalid / s0_axis_tready / s0_axis_tdata / s0_axis_tlast / s0_axis_tkeep  in/out/in/in/in  1/1/DATA_W/1/KEEP_W  source 0 stream.
- s1_axis_tvalid / s1_axis_tready / s1_axis_tdata / s1_axis_tlast / s1_axis_tkeep  in/out/in/in/in  1/1/DATA_W/1/KEEP_W  source 1 stream.
- m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast / m_axis_tkeep  out/in/out/out/out  1/1/DATA_W/1/KEEP_W  to CMAC TX user port.
- grant_id  out  1  source currently granted (valid while busy=1).
- busy  out  1  1 while in XFER state.
- s0_frame_cnt  out  CNT_W  packets accepted from source 0.
- s1_frame_cnt  out  CNT_W  packets accepted from source 1.

Behaviour:
- Reset (async assert, sync release): state IDLE, last_grant=1 (so source 0 wins first tie), skid buffer empty, all outputs 0 (m_axis_tvalid=0, sN_axis_tready=0, grant_id=0, busy=0, counters 0). Reset mid-packet flushes buffer; partial packet is dropped, m_axis_tvalid falls immediately.
- FSM states: IDLE, XFER.
- IDLE: if arb_enable=1 and any sN_tvalid=1, register grant_id, go to XFER next cycle. Both valid: PRIO_MODE=0 picks source != last_grant; PRIO_MODE=1 picks 0.
- XFER: sK_axis_tready = (grant_id==K) && skid not full; ungranted source tready=0 always.
- Beat accepted = tvalid && tready on granted source; beat written into skid buffer, appears on m_axis the cycle after acceptance (1-cycle latency).
- Accepted beat with tlast=1: last_grant<=grant_id; same cycle re-arbitrate with that cycle's tvalids: if arb_enable=1 and a requester is valid, next grant loaded and state stays XFER (zero-bubble boundary; grant may switch or repeat); else go IDLE.
- Round-robin: after tlast from source K, other source wins if valid; if only K valid, K regranted.
- Skid buffer: 2 entries; "not full" = fewer than 2 entries; with m_axis_tready held 1, sustained 1 beat/cycle, including across packet boundaries. m_axis_* stable while m_axis_tvalid=1 and m_axis_tready=0.
- tdata/tkeep/tlast passed unmodified; no checking of tkeep content.
- arb_enable falling mid-packet: current packet runs to tlast, then IDLE; no new grant until arb_enable=1.
- Frame counters: +1 on accepted tlast beat of that source, wrap modulo 2^CNT_W. cnt_clear takes priority over the old value; cnt_clear coincident with increment gives 1.
- busy=1 exactly while state=XFER.

Test Plan:
- Only s0 sends 3 packets of 4 beats, m_axis_tready=1 -> 12 consecutive m_axis beats starting 1 cycle after first acceptance, no gaps, s0_frame_cnt=3, s1_frame_cnt=0.
- s0 and s1 both continuously valid, 2-beat packets, PRIO_MODE=0 -> output packet order s0,s1,s0,s1; no interleaving of beats inside a packet; zero idle cycles at boundaries.
- Same stimulus with PRIO_MODE=1 -> only s0 packets granted; s1_axis_tready stays 0; s1_frame_cnt=0.
- m_axis_tready toggled 1/0 every cycle during a 16-beat packet -> all 16 beats delivered in order, data stable during stalls, sN_axis_tready=0 while buffer holds 2 entries.
- arb_enable dropped at beat 2 of a 5-beat s1 packet, s0 valid -> s1 packet completes (5 beats), FSM returns to IDLE, s0 not granted until arb_enable=1.
- Counter preloaded to 2^32-1 via traffic, then one more packet -> wraps to 0. cnt_clear pulsed on a tlast beat -> counter=1. sys_reset_n asserted mid-packet -> m_axis_tvalid=0 immediately, counters 0.

Source files
------------

// File: rtl/cmac_tx_arbiter_if.sv
// AXI-Stream bundle for one 512-bit CMAC user-side stream.
// Handshake: a beat transfers on a gt_clk rising edge where tvalid and tready
// are both 1; a master holding tvalid=1 keeps tdata/tkeep/tlast stable until
// that edge, and tready may depend only on the slave's registered state.
interface cmac_tx_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [KEEP_W-1:0] tkeep;

  modport master (output tvalid, output tdata, output tlast, output tkeep, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tkeep, output tready);
endinterface

// File: rtl/cmac_tx_arbiter.sv
// Two-source, packet-granular arbiter in front of the CMAC TX user port.
// A granted source streams into a 2-entry output buffer that drives m_axis
// directly from flops; a new grant is taken on the tlast beat itself so
// back-to-back packets leave with no idle cycle between them.
module cmac_tx_arbiter #(
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64,
  parameter int CNT_W     = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic             gt_clk,
  input  logic             sys_reset_n,
  input  logic             arb_enable,
  input  logic             cnt_clear,
  cmac_tx_arbiter_if.slave  s0_axis,
  cmac_tx_arbiter_if.slave  s1_axis,
  cmac_tx_arbiter_if.master m_axis,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] s0_frame_cnt,
  output logic [CNT_W-1:0] s1_frame_cnt
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic [KEEP_W-1:0] buf_keep_q [2];
  logic [KEEP_W-1:0] buf_keep_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];
  logic [CNT_W-1:0]  s0_cnt_q, s0_cnt_d;
  logic [CNT_W-1:0]  s1_cnt_q, s1_cnt_d;

  logic              s0_rdy, s1_rdy, push, pop, not_full;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              inc0, inc1;

  // Winner among the requesters; on a tie round-robin favours the source
  // that did not finish the previous packet, fixed priority favours source 0.
  function automatic logic pick(input logic v0, input logic v1, input logic lg);
    if (v0 && v1) return (PRIO_MODE != 0) ? 1'b0 : ~lg;
    return ~v0;
  endfunction

  assign not_full = (occ_q != 2'd2);
  assign sel_data = grant_q ? s1_axis.tdata : s0_axis.tdata;
  assign sel_keep = grant_q ? s1_axis.tkeep : s0_axis.tkeep;
  assign sel_last = grant_q ? s1_axis.tlast : s0_axis.tlast;
  assign pop      = (occ_q != 2'd0) && m_axis.tready;
  assign inc0     = push && sel_last && !grant_q;
  assign inc1     = push && sel_last && grant_q;

  // Grant FSM: choose a source in IDLE, stream it in XFER, re-arbitrate on tlast.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s0_rdy       = 1'b0;
    s1_rdy       = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
          grant_d = pick(s0_axis.tvalid, s1_axis.tvalid, last_grant_q);
          state_d = XFER;
        end
      end
      XFER: begin
        s0_rdy = !grant_q && not_full;
        s1_rdy = grant_q && not_full;
        push   = grant_q ? (s1_axis.tvalid && s1_rdy) : (s0_axis.tvalid && s0_rdy);
        if (push && sel_last) begin
          last_grant_d = grant_q;
          if (arb_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
            grant_d = pick(s0_axis.tvalid, s1_axis.tvalid, grant_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer bookkeeping: write the accepted beat, advance on m_axis handshake.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_keep_d = buf_keep_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      buf_data_d[wr_ptr_q] = sel_data;
      buf_keep_d[wr_ptr_q] = sel_keep;
      buf_last_d[wr_ptr_q] = sel_last;
    end
  end

  // Frame counters; a clear wins over the old value but keeps a same-cycle increment.
  always_comb begin
    s0_cnt_d = cnt_clear ? CNT_W'(inc0) : s0_cnt_q + CNT_W'(inc0);
    s1_cnt_d = cnt_clear ? CNT_W'(inc1) : s1_cnt_q + CNT_W'(inc1);
  end

  // State registers; reset empties the buffer, dropping any partial packet.
  always_ff @(posedge gt_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_data_q   <= '{default: '0};
      buf_keep_q   <= '{default: '0};
      buf_last_q   <= '{default: 1'b0};
      s0_cnt_q     <= '0;
      s1_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_data_q   <= buf_data_d;
      buf_keep_q   <= buf_keep_d;
      buf_last_q   <= buf_last_d;
      s0_cnt_q     <= s0_cnt_d;
      s1_cnt_q     <= s1_cnt_d;
    end
  end

  assign s0_axis.tready = s0_rdy;
  assign s1_axis.tready = s1_rdy;
  assign m_axis.tvalid  = (occ_q != 2'd0);
  assign m_axis.tdata   = buf_data_q[rd_ptr_q];
  assign m_axis.tkeep   = buf_keep_q[rd_ptr_q];
  assign m_axis.tlast   = buf_last_q[rd_ptr_q];
  assign grant_id       = grant_q;
  assign busy           = (state_q == XFER);
  assign s0_frame_cnt   = s0_cnt_q;
  assign s1_frame_cnt   = s1_cnt_q;

endmodule
